// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppu_pkg
// Purpose  : Shared PPU timing constants, attribute word layout, sprite-evaluator
//            state encoding and pixel-extraction helper.
// Revision : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    localparam int HACTIVE    = 1280;
    localparam int HTOTAL     = 1600;
    localparam int VTOTAL     = 525;
    localparam int EVAL_ABORT = HTOTAL - 2;

    localparam int ATTR_Y_LSB     = 0;
    localparam int ATTR_Y_W       = 10;
    localparam int ATTR_X_LSB     = 10;
    localparam int ATTR_X_W       = 10;
    localparam int ATTR_BASE_LSB  = 20;
    localparam int ATTR_BASE_W    = 8;
    localparam int ATTR_PAL_LSB   = 28;
    localparam int ATTR_PAL_W     = 3;
    localparam int ATTR_HFLIP_BIT = 31;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_RD  = 3'd1,
        A_CHK = 3'd2,
        S_RD  = 3'd3,
        S_LD  = 3'd4
    } eval_state_t;

    // Pixel p of a sprite row lives in bits [2p+1:2p].
    function automatic logic [1:0] row_pixel(input logic [31:0] row, input logic [3:0] idx);
        return row[{idx, 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_line_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_engine_if
// Purpose  : Raster timing, attribute/sprite memory bus and pixel outputs of
//            the sprite line engine.
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_line_engine_if #(
    parameter int NUM_ATTRS = 16,
    parameter int PAL_BITS  = 4
);
    localparam int AW = $clog2(NUM_ATTRS);

    logic [10:0]         hcount;
    logic [9:0]          vcount;
    logic [AW-1:0]       attr_addr;
    logic [31:0]         attr_data;
    logic [7:0]          spr_addr;
    logic [31:0]         spr_data;
    logic [PAL_BITS-1:0] color_idx;
    logic                overflow;
    logic                busy;

    modport master (
        input  hcount, vcount, attr_data, spr_data,
        output attr_addr, spr_addr, color_idx, overflow, busy
    );

    modport slave (
        output hcount, vcount, attr_data, spr_data,
        input  attr_addr, spr_addr, color_idx, overflow, busy
    );

endinterface
`default_nettype wire

// File: rtl/sprite_slot.sv
`default_nettype none
// ============================================================================
// Module   : sprite_slot
// Purpose  : One loaded sprite row; reports whether it paints the current
//            column with an opaque pixel and the resulting palette index.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_slot
    import ppu_pkg::*;
#(
    parameter int PAL_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                load,
    input  logic [9:0]          load_x,
    input  logic [31:0]         load_row,
    input  logic [2:0]          load_pal,
    input  logic                load_hflip,
    input  logic [9:0]          column,
    output logic                hit,
    output logic [PAL_BITS-1:0] colour
);

    logic        valid;
    logic [9:0]  x;
    logic [31:0] row;
    logic [2:0]  pal;
    logic        hflip;

    logic [10:0] off;
    logic        covers;
    logic [3:0]  idx;
    logic [1:0]  pix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            x     <= '0;
            row   <= '0;
            pal   <= '0;
            hflip <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            x     <= load_x;
            row   <= load_row;
            pal   <= load_pal;
            hflip <= load_hflip;
        end
    end

    // Columns left of x wrap to large unsigned offsets and fall outside 0..15.
    assign off    = {1'b0, column} - {1'b0, x};
    assign covers = valid && (off < 11'd16);
    assign idx    = hflip ? (4'd15 - off[3:0]) : off[3:0];
    assign pix    = row_pixel(row, idx);
    assign hit    = covers && (pix != 2'd0);
    assign colour = PAL_BITS'(pal) + PAL_BITS'(pix);

endmodule
`default_nettype wire

// File: rtl/sprite_line_engine.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_engine
// Purpose  : Scans the attribute table during horizontal blank, loads the rows
//            of sprites crossing the next line, and composites them per pixel.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_line_engine
    import ppu_pkg::*;
#(
    parameter int NUM_ATTRS   = 16,
    parameter int MAX_VISIBLE = 4,
    parameter int SPRITE_ROWS = 16,
    parameter int PAL_BITS    = 4
) (
    input logic                  clk,
    input logic                  reset,
    sprite_line_engine_if.master bus
);

    localparam int AW = $clog2(NUM_ATTRS);
    localparam int VW = $clog2(MAX_VISIBLE + 1);

    eval_state_t         state;
    logic [AW-1:0]       ac;
    logic [VW-1:0]       vc;
    logic [7:0]          spr_addr_q;
    logic                overflow_q;
    logic [PAL_BITS-1:0] color_q;

    logic [9:0]          target;
    logic [9:0]          a_y;
    logic [9:0]          a_x;
    logic [7:0]          a_base;
    logic [2:0]          a_pal;
    logic                a_hflip;
    logic [10:0]         row_off;
    logic                attr_hit;
    logic                start;
    logic                abort;
    logic                last_attr;
    logic                slot_clear;

    logic [MAX_VISIBLE-1:0] slot_load;
    logic [MAX_VISIBLE-1:0] slot_hit;
    logic [PAL_BITS-1:0]    slot_col [MAX_VISIBLE];
    logic [PAL_BITS-1:0]    pixel;

    assign target  = (bus.vcount == 10'(VTOTAL - 1)) ? 10'd0 : bus.vcount + 10'd1;
    assign a_y     = bus.attr_data[ATTR_Y_LSB +: ATTR_Y_W];
    assign a_x     = bus.attr_data[ATTR_X_LSB +: ATTR_X_W];
    assign a_base  = bus.attr_data[ATTR_BASE_LSB +: ATTR_BASE_W];
    assign a_pal   = bus.attr_data[ATTR_PAL_LSB +: ATTR_PAL_W];
    assign a_hflip = bus.attr_data[ATTR_HFLIP_BIT];

    // 11-bit compare so sprites near y=1023 never wrap onto the top lines.
    assign row_off   = {1'b0, target} - {1'b0, a_y};
    assign attr_hit  = ({1'b0, target} >= {1'b0, a_y}) && (row_off < 11'(SPRITE_ROWS));
    assign start     = (bus.hcount == 11'(HACTIVE));
    assign abort     = (bus.hcount == 11'(EVAL_ABORT));
    assign last_attr = (ac == AW'(NUM_ATTRS - 1));
    assign slot_clear = (state == IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ac         <= '0;
            vc         <= '0;
            spr_addr_q <= '0;
            overflow_q <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ac         <= '0;
                        vc         <= '0;
                        overflow_q <= 1'b0;
                        state      <= A_RD;
                    end
                end
                A_RD: state <= A_CHK;
                A_CHK: begin
                    if (attr_hit) begin
                        if (vc == VW'(MAX_VISIBLE)) begin
                            overflow_q <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            spr_addr_q <= a_base + row_off[7:0];
                            state      <= S_RD;
                        end
                    end else if (last_attr) begin
                        state <= IDLE;
                    end else begin
                        ac    <= ac + AW'(1);
                        state <= A_RD;
                    end
                end
                S_RD: state <= S_LD;
                S_LD: begin
                    vc <= vc + VW'(1);
                    if (last_attr) begin
                        state <= IDLE;
                    end else begin
                        ac    <= ac + AW'(1);
                        state <= A_RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < MAX_VISIBLE; i++) begin : g_slot
        // attr_addr is held through S_RD/S_LD, so attr_data still describes this sprite.
        assign slot_load[i] = (state == S_LD) && !abort && (vc == VW'(i));

        sprite_slot #(
            .PAL_BITS (PAL_BITS)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .clear      (slot_clear),
            .load       (slot_load[i]),
            .load_x     (a_x),
            .load_row   (bus.spr_data),
            .load_pal   (a_pal),
            .load_hflip (a_hflip),
            .column     (bus.hcount[10:1]),
            .hit        (slot_hit[i]),
            .colour     (slot_col[i])
        );
    end

    always_comb begin
        pixel = '0;
        for (int i = MAX_VISIBLE - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                pixel = slot_col[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_q <= '0;
        end else begin
            color_q <= (bus.hcount < 11'(HACTIVE)) ? pixel : '0;
        end
    end

    assign bus.attr_addr = ac;
    assign bus.spr_addr  = spr_addr_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (state != IDLE);
    assign bus.color_idx = color_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_line_engine
// Purpose  : Directed scoreboard bench for sprite_line_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_line_engine;

    localparam int K_COL  = 0;
    localparam int K_OVF  = 1;
    localparam int K_BUSY = 2;
    localparam int K_AA   = 3;
    localparam int K_SA   = 4;

    typedef struct {
        int    tag;
        int    kind;
        int    exp;
        string name;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic [31:0] attr_mem [16];
    logic [31:0] spr_mem  [256];

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    event imm_ev;

    always #5 clk = ~clk;

    sprite_line_engine_if #(.NUM_ATTRS(16), .PAL_BITS(4)) bus ();

    sprite_line_engine #(
        .NUM_ATTRS   (16),
        .MAX_VISIBLE (4),
        .SPRITE_ROWS (16),
        .PAL_BITS    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) begin
        bus.attr_data <= attr_mem[bus.attr_addr];
        bus.spr_data  <= spr_mem[bus.spr_addr];
    end

    function automatic logic [31:0] mk(input logic [9:0] y, input logic [9:0] x,
                                       input logic [7:0] base, input logic [2:0] pal,
                                       input logic hf);
        return {hf, pal, base, x, y};
    endfunction

    function automatic int actual(input int kind);
        case (kind)
            K_COL:   return int'(bus.color_idx);
            K_OVF:   return int'(bus.overflow);
            K_BUSY:  return int'(bus.busy);
            K_AA:    return int'(bus.attr_addr);
            default: return int'(bus.spr_addr);
        endcase
    endfunction

    task automatic push(input int kind, input int exp, input string name, input int tag);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic scan(input int limit);
        exp_t e;
        int   act;
        while (sb.size() > 0 && sb[0].tag <= limit) begin
            e   = sb.pop_front();
            act = actual(e.kind);
            checks++;
            if (act != e.exp) begin
                failures++;
                $display("FAIL %s cycle=%0d actual=%0d expected=%0d", e.name, e.tag, act, e.exp);
            end
        end
    endtask

    // Monitor: the output for the hcount driven in cycle n is visible by the
    // negedge of cycle n+1; asynchronous-reset checks are sampled on demand.
    always @(negedge clk) scan(cyc - 1);
    always @(imm_ev) scan(cyc);

    task automatic drive(input int h, input int v, input bit chk, input int exp_col);
        @(posedge clk);
        #1;
        bus.hcount = 11'(h);
        bus.vcount = 10'(v);
        cyc++;
        if (chk) push(K_COL, exp_col, "color", cyc);
    endtask

    task automatic run_blank(input int v, input int exp_ovf);
        for (int h = 1280; h < 1600; h++) begin
            drive(h, v, 1'b1, 0);
            if (h == 1280) push(K_BUSY, 1, "busy_start", cyc);
            if (h == 1597) begin
                push(K_BUSY, 0, "busy_done", cyc);
                push(K_OVF, exp_ovf, "overflow", cyc);
            end
        end
    endtask

    task automatic show(input int v, input int h0, input int h1,
                        input int c_lo, input int c_hi, input int val);
        for (int h = h0; h <= h1; h++) begin
            drive(h, v, 1'b1, ((h / 2) >= c_lo && (h / 2) <= c_hi) ? val : 0);
        end
    endtask

    task automatic clear_attrs();
        for (int i = 0; i < 16; i++) attr_mem[i] = mk(10'd1000, 10'd0, 8'd0, 3'd0, 1'b0);
    endtask

    task automatic check_now(input int kind, input int exp, input string name);
        push(kind, exp, name, cyc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.hcount = '0;
        bus.vcount = '0;
        for (int i = 0; i < 256; i++) spr_mem[i] = '0;
        clear_attrs();
        #2 reset = 1'b1;

        drive(0, 0, 1'b0, 0);
        check_now(K_COL,  0, "rst_color");
        check_now(K_OVF,  0, "rst_overflow");
        check_now(K_BUSY, 0, "rst_busy");
        check_now(K_AA,   0, "rst_attr_addr");
        check_now(K_SA,   0, "rst_spr_addr");
        drive(0, 0, 1'b0, 0);
        reset = 1'b0;

        // Single pixel at column 50, plus a wide sprite at the right edge.
        attr_mem[0] = mk(10'd100, 10'd50, 8'd0, 3'd4, 1'b0);
        attr_mem[1] = mk(10'd100, 10'd630, 8'd1, 3'd4, 1'b0);
        spr_mem[0]  = 32'h0000_0001;
        spr_mem[1]  = 32'h5555_5555;
        run_blank(99, 0);
        show(100, 90, 140, 50, 50, 5);
        show(100, 1250, 1279, 630, 645, 5);

        // Horizontal flip moves pixel 0 to column x+15.
        clear_attrs();
        attr_mem[0] = mk(10'd100, 10'd50, 8'd0, 3'd4, 1'b1);
        run_blank(99, 0);
        show(100, 96, 140, 65, 65, 5);

        // Overlap: lower attribute index wins unless transparent.
        clear_attrs();
        attr_mem[0] = mk(10'd200, 10'd50, 8'd1, 3'd0, 1'b0);
        attr_mem[1] = mk(10'd200, 10'd50, 8'd0, 3'd7, 1'b0);
        spr_mem[0]  = 32'h5555_5555;
        spr_mem[1]  = 32'h5555_5555;
        run_blank(199, 0);
        show(200, 96, 136, 50, 65, 1);
        spr_mem[1] = 32'h0000_0000;
        run_blank(199, 0);
        show(200, 96, 136, 50, 65, 8);

        // Five hits with four slots: overflow, fifth sprite never shown.
        clear_attrs();
        for (int i = 0; i < 5; i++) attr_mem[i] = mk(10'd300, 10'(10 + 20 * i), 8'd0, 3'(i + 1), 1'b0);
        run_blank(299, 1);
        show(300, 136, 145, 70, 85, 5);
        show(300, 168, 190, 70, 85, 5);
        check_now(K_OVF, 1, "overflow_hold");
        clear_attrs();
        run_blank(300, 0);

        // y=1020 must not wrap onto line 4.
        attr_mem[0] = mk(10'd1020, 10'd50, 8'd0, 3'd3, 1'b0);
        spr_mem[8]  = 32'h5555_5555;
        run_blank(3, 0);
        show(4, 96, 104, 1, 0, 0);

        // Last line hits with row offset 0.
        clear_attrs();
        attr_mem[0] = mk(10'd524, 10'd20, 8'd2, 3'd1, 1'b0);
        spr_mem[2]  = 32'h0000_0003;
        run_blank(523, 0);
        show(524, 36, 44, 20, 20, 4);

        // vcount=524 evaluates line 0.
        clear_attrs();
        attr_mem[0] = mk(10'd0, 10'd100, 8'd5, 3'd2, 1'b0);
        spr_mem[5]  = 32'h0000_0008;
        run_blank(524, 0);
        show(0, 198, 206, 101, 101, 4);

        // Reset mid-line clears the output immediately and invalidates slots.
        drive(202, 0, 1'b1, 4);
        drive(203, 0, 1'b0, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_now(K_COL,  0, "midline_rst_color");
        check_now(K_BUSY, 0, "midline_rst_busy");
        -> imm_ev;
        #1;
        drive(202, 0, 1'b0, 0);
        drive(202, 0, 1'b0, 0);
        reset = 1'b0;
        drive(202, 0, 1'b1, 0);
        drive(203, 0, 1'b1, 0);

        // Reset during S_RD of the third attribute.
        clear_attrs();
        attr_mem[2] = mk(10'd50, 10'd10, 8'd7, 3'd1, 1'b0);
        spr_mem[10] = 32'h0000_0001;
        for (int h = 1280; h <= 1287; h++) begin
            drive(h, 52, 1'b1, 0);
            if (h == 1280) push(K_BUSY, 1, "busy_start", cyc);
            if (h == 1286) begin
                push(K_BUSY, 1, "srd_busy", cyc);
                push(K_SA, 10, "srd_spr_addr", cyc);
                push(K_AA, 2, "srd_attr_addr", cyc);
            end
        end
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_now(K_BUSY, 0, "srd_rst_busy");
        check_now(K_AA,   0, "srd_rst_attr_addr");
        check_now(K_SA,   0, "srd_rst_spr_addr");
        check_now(K_OVF,  0, "srd_rst_overflow");
        check_now(K_COL,  0, "srd_rst_color");
        -> imm_ev;
        #1;
        for (int h = 1288; h <= 1290; h++) drive(h, 52, 1'b1, 0);
        reset = 1'b0;
        for (int h = 1291; h < 1600; h++) begin
            drive(h, 52, 1'b1, 0);
            if (h == 1500) push(K_BUSY, 0, "no_restart", cyc);
        end
        run_blank(52, 0);
        show(53, 16, 26, 10, 10, 2);

        drive(0, 0, 1'b0, 0);
        drive(0, 0, 1'b0, 0);
        drive(0, 0, 1'b0, 0);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures += sb.size();
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
